// File: rtl/tone_sequencer.sv
// Square-wave tone sequencer: plays one of 8 notes (C5..C6) from manual switches,
// or steps through an 8-note scale with a fixed duration per note.
module tone_sequencer #(
  parameter int N           = 16,
  parameter int DUR_W       = 26,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int NUM_NOTES   = 8,
  parameter int TABLE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       tone_en,
  input  logic [2:0] note_sel,
  input  logic       start,
  input  logic       stop,
  output logic       tone_out,
  output logic [2:0] note_idx,
  output logic       active,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    PLAY   = 2'd2
  } state_t;

  localparam logic [DUR_W-1:0] DUR_LAST  = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [2:0]       NOTE_LAST = 3'(NUM_NOTES - 1);

  // Half-period table; a scaled entry never drops below 1 so the divider always terminates.
  function automatic logic [N-1:0] hp_calc(input int idx);
    int base;
    case (idx)
      0:       base = 47801;
      1:       base = 42589;
      2:       base = 37936;
      3:       base = 35816;
      4:       base = 31928;
      5:       base = 28409;
      6:       base = 25329;
      default: base = 23900;
    endcase
    base = base >> TABLE_SHIFT;
    if (base < 1) base = 1;
    return N'(base);
  endfunction

  logic [N-1:0] hp_tab [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_hp
    assign hp_tab[gi] = hp_calc(gi);
  end

  state_t           state_q;
  logic [N-1:0]     half_cnt_q;
  logic [DUR_W-1:0] dur_cnt_q;
  logic [2:0]       note_idx_q;
  logic             tone_q;
  logic             active_q;
  logic             busy_q;
  logic             done_q;

  logic [N-1:0]     hp_cur;
  logic [N-1:0]     half_cnt_d;
  logic             tone_d;

  assign hp_cur = hp_tab[note_idx_q];

  // Divider step for the note currently sounding.
  always_comb begin
    half_cnt_d = half_cnt_q + N'(1);
    tone_d     = tone_q;
    if (half_cnt_q == hp_cur - N'(1)) begin
      half_cnt_d = '0;
      tone_d     = ~tone_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      dur_cnt_q  <= '0;
      note_idx_q <= '0;
      tone_q     <= 1'b0;
      active_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tone_q     <= 1'b0;
          half_cnt_q <= '0;
          note_idx_q <= '0;
          if (!stop && start && mode) begin
            state_q   <= PLAY;
            dur_cnt_q <= '0;
            active_q  <= 1'b1;
            busy_q    <= 1'b1;
          end else if (!stop && !mode && tone_en) begin
            state_q    <= MANUAL;
            note_idx_q <= note_sel;
            active_q   <= 1'b1;
          end
        end

        MANUAL: begin
          if (!tone_en || mode) begin
            state_q    <= IDLE;
            tone_q     <= 1'b0;
            half_cnt_q <= '0;
            note_idx_q <= '0;
            active_q   <= 1'b0;
          end else if (note_sel != note_idx_q) begin
            note_idx_q <= note_sel;
            half_cnt_q <= '0;
          end else begin
            half_cnt_q <= half_cnt_d;
            tone_q     <= tone_d;
          end
        end

        PLAY: begin
          if (stop) begin
            state_q    <= IDLE;
            tone_q     <= 1'b0;
            half_cnt_q <= '0;
            note_idx_q <= '0;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
          end else if (dur_cnt_q == DUR_LAST) begin
            dur_cnt_q <= '0;
            if (note_idx_q < NOTE_LAST) begin
              note_idx_q <= note_idx_q + 3'd1;
              half_cnt_q <= '0;
            end else begin
              state_q    <= IDLE;
              tone_q     <= 1'b0;
              half_cnt_q <= '0;
              note_idx_q <= '0;
              active_q   <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end else begin
            dur_cnt_q  <= dur_cnt_q + DUR_W'(1);
            half_cnt_q <= half_cnt_d;
            tone_q     <= tone_d;
          end
        end

        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tone_out = tone_q;
  assign note_idx = note_idx_q;
  assign active   = active_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: main instance with scaled-down timing and a
// second instance with HP=1 / two-cycle notes for the boundary case.
module tb_tone_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, tone_en, start, stop;
  logic [2:0] note_sel;
  logic       tone_out, active, busy, done;
  logic [2:0] note_idx;

  logic       mode_b, tone_en_b, start_b, stop_b;
  logic [2:0] note_sel_b;
  logic       tone_out_b, active_b, busy_b, done_b;
  logic [2:0] note_idx_b;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  tone_sequencer #(
    .N(16), .DUR_W(26), .NOTE_CYCLES(10), .NUM_NOTES(8), .TABLE_SHIFT(8)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .tone_en(tone_en), .note_sel(note_sel),
    .start(start), .stop(stop), .tone_out(tone_out), .note_idx(note_idx),
    .active(active), .busy(busy), .done(done)
  );

  tone_sequencer #(
    .N(16), .DUR_W(26), .NOTE_CYCLES(2), .NUM_NOTES(8), .TABLE_SHIFT(15)
  ) dut_b (
    .clk(clk), .rst(rst), .mode(mode_b), .tone_en(tone_en_b), .note_sel(note_sel_b),
    .start(start_b), .stop(stop_b), .tone_out(tone_out_b), .note_idx(note_idx_b),
    .active(active_b), .busy(busy_b), .done(done_b)
  );

  // Status word layout: {tone_out, note_idx[2:0], active, busy, done}
  function automatic int st(int tone, int note, int act, int bsy, int dn);
    return (tone << 6) | (note << 3) | (act << 2) | (bsy << 1) | dn;
  endfunction

  function automatic logic [6:0] stat_a();
    return {tone_out, note_idx, active, busy, done};
  endfunction

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    mode = 0; tone_en = 0; start = 0; stop = 0; note_sel = 0;
    mode_b = 0; tone_en_b = 0; start_b = 0; stop_b = 0; note_sel_b = 0;
    repeat (3) tick();
    push("reset_state", st(0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (stat_a() !== e.val[6:0]) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", e.tag, stat_a(), e.val[6:0]);
    end
    rst = 1'b0;
    tick();
    // Start a sequence and reset it in the middle of note 2
    mode = 1; start = 1;
    tick();
    start = 0;
    repeat (24) tick();
    push("pre_rst_play", st(0, 2, 1, 1, 0));
    e = sb.pop_front(); vectors++;
    if (stat_a() !== e.val[6:0]) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", e.tag, stat_a(), e.val[6:0]);
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) push("rst_mid_play", st(0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      e = sb.pop_front(); vectors++;
      if (stat_a() !== e.val[6:0]) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b, expected %b", e.tag, k, stat_a(), e.val[6:0]);
      end
    end
    mode = 0;
    rst = 1'b0;
    for (int k = 0; k < 90; k++) push("post_rst_idle", st(0, 0, 0, 0, 0));
    for (int k = 0; k < 90; k++) begin
      tick();
      e = sb.pop_front(); vectors++;
      if (stat_a() !== e.val[6:0]) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b, expected %b", e.tag, k, stat_a(), e.val[6:0]);
      end
    end
  endtask

  task automatic test_manual();
    exp_t e;
    logic prev;
    int   t;
    mode = 0; tone_en = 1; note_sel = 0;
    // First toggle 186 edges after entry, observed on the following negedge
    push("man_first_toggle", 187);
    push("man_half_period", 186);
    push("man_half_period", 186);
    for (int k = 0; k < 3; k++) begin
      prev = tone_out;
      t = 0;
      while (tone_out === prev && t < 1000) begin
        tick();
        t++;
      end
      e = sb.pop_front(); vectors++;
      if (t !== e.val) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %0d cycles, expected %0d", e.tag, k, t, e.val);
      end
    end
    push("man_running", st(1, 0, 1, 0, 0));
    e = sb.pop_front(); vectors++;
    if (stat_a() !== e.val[6:0]) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", e.tag, stat_a(), e.val[6:0]);
    end
    tone_en = 0;
    tick();
    push("man_disable", st(0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (stat_a() !== e.val[6:0]) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", e.tag, stat_a(), e.val[6:0]);
    end
  endtask

  task automatic test_note_change();
    exp_t e;
    logic prev;
    int   t;
    mode = 0; tone_en = 1; note_sel = 0;
    repeat (50) tick();
    note_sel = 7;
    push("chg_note_idx", st(0, 7, 1, 0, 0));
    push("chg_first_toggle", 94);
    push("chg_half_period", 93);
    tick();
    e = sb.pop_front(); vectors++;
    if (stat_a() !== e.val[6:0]) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", e.tag, stat_a(), e.val[6:0]);
    end
    for (int k = 0; k < 2; k++) begin
      prev = tone_out;
      t = (k == 0) ? 1 : 0;
      while (tone_out === prev && t < 1000) begin
        tick();
        t++;
      end
      e = sb.pop_front(); vectors++;
      if (t !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %0d cycles, expected %0d", e.tag, t, e.val);
      end
    end
    tone_en = 0;
    note_sel = 0;
    tick();
  endtask

  task automatic test_auto();
    exp_t e;
    int   n;
    mode = 1; tone_en = 0;
    start = 1;
    for (int t = 1; t <= 85; t++) begin
      n = t - 1;
      push("auto_step", st(0, (n < 80) ? n / 10 : 0, (n < 80) ? 1 : 0,
                           (n < 80) ? 1 : 0, (n == 80) ? 1 : 0));
    end
    for (int t = 1; t <= 85; t++) begin
      tick();
      start = 0;
      e = sb.pop_front(); vectors++;
      if (stat_a() !== e.val[6:0]) begin
        miscompares++;
        $display("FAIL %s[t=%0d]: got %b, expected %b", e.tag, t, stat_a(), e.val[6:0]);
      end
    end
    mode = 0;
  endtask

  task automatic test_abort();
    exp_t e;
    int   done_seen;
    mode = 1; tone_en = 0;
    start = 1;
    tick();
    // Retrigger at t=15 must not restart; note 3 is due at t=35
    for (int k = 1; k < 35; k++) begin
      start = (k == 15);
      tick();
    end
    start = 0;
    push("abort_pre_stop", st(0, 3, 1, 1, 0));
    push("abort_post_stop", st(0, 0, 0, 0, 0));
    push("abort_no_done", 0);
    push("start_stop_idle", st(0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (stat_a() !== e.val[6:0]) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", e.tag, stat_a(), e.val[6:0]);
    end
    stop = 1;
    tick();
    stop = 0;
    e = sb.pop_front(); vectors++;
    if (stat_a() !== e.val[6:0]) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", e.tag, stat_a(), e.val[6:0]);
    end
    done_seen = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    e = sb.pop_front(); vectors++;
    if (done_seen !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %0d done pulses, expected %0d", e.tag, done_seen, e.val);
    end
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    e = sb.pop_front(); vectors++;
    if (stat_a() !== e.val[6:0]) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", e.tag, stat_a(), e.val[6:0]);
    end
    mode = 0;
    tick();
  endtask

  task automatic test_boundary();
    exp_t e;
    int   n;
    mode_b = 0; tone_en_b = 1; note_sel_b = 0;
    // HP=1: output flips on every edge after entry
    for (int t = 1; t <= 9; t++) push("hp1_tone", (t - 1) & 1);
    for (int t = 1; t <= 9; t++) begin
      tick();
      e = sb.pop_front(); vectors++;
      if (tone_out_b !== e.val[0]) begin
        miscompares++;
        $display("FAIL %s[t=%0d]: got %b, expected %b", e.tag, t, tone_out_b, e.val[0]);
      end
    end
    tone_en_b = 0;
    tick();
    mode_b = 1;
    start_b = 1;
    for (int t = 1; t <= 20; t++) begin
      n = t - 1;
      push("short_seq", ((n < 16 ? n / 2 : 0) << 2) | ((n < 16 ? 1 : 0) << 1) |
                        (n == 16 ? 1 : 0));
    end
    for (int t = 1; t <= 20; t++) begin
      tick();
      start_b = 0;
      e = sb.pop_front(); vectors++;
      if ({note_idx_b, busy_b, done_b} !== e.val[4:0]) begin
        miscompares++;
        $display("FAIL %s[t=%0d]: got %b, expected %b", e.tag, t,
                 {note_idx_b, busy_b, done_b}, e.val[4:0]);
      end
    end
    mode_b = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_manual();
    test_note_change();
    test_auto();
    test_abort();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
